aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequencer for the AES round datapath. Accepts one block per valid/ready handshake, steps an internal 4-bit round counter through the initial AddRoundKey, the middle rounds and the final round. Drives the state-register, key-schedule and MixColumns enables, then presents a result-valid handshake. Sits between the top-level I/O and the round/key-expansion datapath.

Parameters:
NR, 10, number of AES rounds; legal values 10, 12 and 14; any other value is unsupported.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  plaintext/key present on datapath inputs
in_ready  output  1  controller can accept a block
out_ready  input  1  consumer accepts the result
out_valid  output  1  datapath state register holds the finished block
round  output  4  current round index, 0..NR
load_sel  output  1  state mux selects input block XOR cipher key (round 0)
state_en  output  1  state register write enable
key_en  output  1  round-key register advance/load enable
mix_en  output  1  MixColumns in path (0 = bypass)
busy  output  1  high in LOAD, ROUND and FINAL

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, round=0. All outputs 0 except in_ready=1.
- States: IDLE, LOAD, ROUND, FINAL, DONE. State register and round counter are registered; all outputs decode from them (Moore).
- IDLE: in_ready=1. in_valid=1 at a rising edge -> LOAD. Otherwise stay in IDLE.
- LOAD, 1 cycle: round=0, load_sel=1, state_en=1, key_en=1, mix_en=0. Next state is ROUND with round=1.
- ROUND, cycles round=1..NR-1: state_en=1, key_en=1, mix_en=1, load_sel=0. round increments by 1 per cycle. When round=NR-1, next state is FINAL with round=NR.
- FINAL, 1 cycle: round=NR, state_en=1, key_en=1, mix_en=0. Next state is DONE.
- DONE: out_valid=1, round holds NR, and all enables are 0 so the result stays stable. Leaves when out_ready=1 at an edge: next state IDLE, round=0.
- Latency: out_valid rises NR+2 cycles after the accepting edge (12 for NR=10). Minimum block-to-block interval is NR+3 cycles.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored; there is no queueing.
- out_ready outside DONE is ignored. out_valid is never withdrawn before out_ready=1.
- Round counter: 4-bit, no wrap within an operation (max value 14). Cleared only on the DONE->IDLE transition or by reset.
- Reset mid-operation: immediate return to IDLE/round 0. The partial block is discarded and out_valid is not produced.
- At most one state transition per cycle. Illegal state encodings recover to IDLE.

Optional Feature:
AES_CTRL_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 at an edge in LOAD, ROUND or FINAL -> IDLE, round=0, out_valid is not produced.
  - While abort=1 in those states, state_en and key_en are forced to 0 combinationally.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port, and operation cannot be cancelled except by rst.

Test Plan:
- Reset: drive rst=0 mid-cycle with clk stopped -> outputs update asynchronously: in_ready=1, round=0, out_valid=0, busy=0.
- Single block, NR=10: in_valid pulse at edge 0 -> LOAD in cycle 1 (load_sel=1). Then round 1..9 with mix_en=1, round=10 with mix_en=0, and out_valid=1 from cycle 12. Exactly 11 state_en pulses.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, round=10, state_en=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- Busy input: in_valid held high throughout -> second block accepted only on the first IDLE cycle after DONE. Interval between LOAD cycles is 13.
- Reset mid-operation: rst=0 at round 5 -> IDLE immediately. No out_valid follows. A new block afterwards completes normally in 12 cycles.
- NR=14 build with AES_CTRL_ABORT_EN: full run reaches round=14 with out_valid at cycle 16. A second run with abort=1 at round 7 -> IDLE next cycle, no out_valid, and state_en=0 during the abort cycle.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: block handshake and round-datapath control bundle for aes_round_ctrl
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] round;
    logic       load_sel;
    logic       state_en;
    logic       key_en;
    logic       mix_en;
    logic       busy;
    modport master (
        input  in_valid, out_ready,
        output in_ready, out_valid, round, load_sel, state_en, key_en, mix_en, busy
    );
    modport slave (
        output in_valid, out_ready,
        input  in_ready, out_valid, round, load_sel, state_en, key_en, mix_en, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer (IDLE/LOAD/ROUND/FINAL/DONE); define AES_CTRL_ABORT_EN to add the abort input
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input logic              clk,
    input logic              rst,
`ifdef AES_CTRL_ABORT_EN
    input logic              abort,
`endif
    aes_round_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       in_ready_q, out_valid_q, load_sel_q, mix_en_q, busy_q;
    logic       abort_w;
    logic       kill;
`ifdef AES_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif
    // abort only matters while a block is in flight; busy_q marks LOAD/ROUND/FINAL
    assign kill = abort_w & busy_q;
    // Next state and round counter; unknown encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            IDLE:  state_d = bus.in_valid ? LOAD : IDLE;
            LOAD: begin
                state_d = ROUND;
                round_d = 4'd1;
            end
            ROUND: begin
                round_d = round_q + 4'd1;
                state_d = (round_q == 4'(NR - 1)) ? FINAL : ROUND;
            end
            FINAL: state_d = DONE;
            DONE: begin
                state_d = bus.out_ready ? IDLE : DONE;
                round_d = bus.out_ready ? 4'd0 : round_q;
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
            end
        endcase
        if (kill) begin
            state_d = IDLE;
            round_d = 4'd0;
        end
    end
    // State, round counter and Moore outputs registered together from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            load_sel_q  <= 1'b0;
            mix_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            in_ready_q  <= state_d == IDLE;
            out_valid_q <= state_d == DONE;
            load_sel_q  <= state_d == LOAD;
            mix_en_q    <= state_d == ROUND;
            busy_q      <= state_d inside {LOAD, ROUND, FINAL};
        end
    end
    // State and key registers write on every busy cycle unless an abort is pending
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.round     = round_q;
    assign bus.load_sel  = load_sel_q;
    assign bus.mix_en    = mix_en_q;
    assign bus.busy      = busy_q;
    assign bus.state_en  = busy_q & ~abort_w;
    assign bus.key_en    = busy_q & ~abort_w;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed self-checking bench for aes_round_ctrl (NR=14 with abort when AES_CTRL_ABORT_EN is defined)
module tb_aes_round_ctrl;
`ifdef AES_CTRL_ABORT_EN
    localparam int NR = 14;
    logic abort = 1'b0;
`else
    localparam int NR = 10;
`endif
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    aes_round_ctrl_if bus ();
    aes_round_ctrl #(.NR(NR)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus)
    );
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    // Called one cycle after the accepting edge; ends in the first DONE cycle
    task automatic run_block();
        int pulses = 0;
        for (int c = 1; c <= NR + 2; c++) begin
            chk("round", 32'(bus.round), (c <= NR + 1) ? c - 1 : NR);
            chk("load_sel", 32'(bus.load_sel), 32'(c == 1));
            chk("mix_en", 32'(bus.mix_en), 32'(c >= 2 && c <= NR));
            chk("key_en", 32'(bus.key_en), 32'(c <= NR + 1));
            chk("busy", 32'(bus.busy), 32'(c <= NR + 1));
            chk("in_ready_busy", 32'(bus.in_ready), 0);
            chk("out_valid", 32'(bus.out_valid), 32'(c == NR + 2));
            pulses += int'(bus.state_en);
            if (c < NR + 2) step();
        end
        chk("state_en_pulses", pulses, NR + 1);
    endtask
    task automatic no_out_valid(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            seen += int'(bus.out_valid);
        end
        chk(tag, seen, 0);
    endtask
    initial begin
        int load_cyc;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_round", 32'(bus.round), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_state_en", 32'(bus.state_en), 0);
        #2 rst = 1'b1;
        clk_en = 1'b1;
        step();
        step();
        chk("idle_hold", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        run_block();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_round", 32'(bus.round), NR);
            chk("bp_state_en", 32'(bus.state_en), 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("rel_in_ready", 32'(bus.in_ready), 1);
        chk("rel_round", 32'(bus.round), 0);
        chk("rel_out_valid", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b1;
        step();
        load_cyc = cyc;
        run_block();
        bus.out_ready = 1'b1;
        step();
        chk("b2b_idle", 32'(bus.in_ready), 1);
        step();
        bus.out_ready = 1'b0;
        chk("b2b_load", 32'(bus.load_sel), 1);
        chk("b2b_interval", cyc - load_cyc, NR + 3);
        bus.in_valid = 1'b0;
        run_block();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_round", 32'(bus.round), 5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_round", 32'(bus.round), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        #1 rst = 1'b1;
        no_out_valid("mid_rst_no_out", NR + 3);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        run_block();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("after_rst_idle", 32'(bus.in_ready), 1);
`ifdef AES_CTRL_ABORT_EN
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("ab_round", 32'(bus.round), 7);
        abort = 1'b1;
        #1;
        chk("ab_state_en", 32'(bus.state_en), 0);
        chk("ab_key_en", 32'(bus.key_en), 0);
        step();
        abort = 1'b0;
        chk("ab_in_ready", 32'(bus.in_ready), 1);
        chk("ab_round0", 32'(bus.round), 0);
        chk("ab_busy", 32'(bus.busy), 0);
        no_out_valid("ab_no_out", NR + 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle_ignored", 32'(bus.in_ready), 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
